cell_config_loader: RTL and testbench

//   Streams PORT_WIDTH-bit configuration words into a DIMY-row stack of cell_row instances.

---
 rtl/cell_pkg.sv | 30 +++
 rtl/cell_config_loader.sv | 134 +++++++++++++
 tb/tb_cell_config_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cell_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_pkg
//  Description : Shared types and sizing helpers for the cell array and its
//                configuration loader.
//                  - load_state_e : loader sequencing states
//                  - calc_slots() : config words per row
//                  - idx_width()  : counter width for N positions, minimum 1
//  Revision    : 1.0  initial release
// ============================================================================
package cell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // Each cell holds 4 config bits, so a row is DIMX*4 bits wide.
    function automatic int calc_slots(input int dimx, input int port_width);
        return (dimx * 4) / port_width;
    endfunction

    // A counter over a single position still needs one bit to exist.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cell_config_loader
//  Description : Streams PORT_WIDTH-bit config words into a DIMY-row stack of
//                cell rows, row-major and slot-ascending. Each accepted word
//                is merged into the shared row RAM bus and a single one-hot
//                write enable is raised for one cycle.
//  Ports       :
//    clk        in   1            clock, rising edge
//    rst_n      in   1            asynchronous active-low reset
//    start      in   1            begin full-array load (IDLE only)
//    abort      in   1            cancel load in progress
//    cfg_data   in   PORT_WIDTH   config word
//    cfg_valid  in   1            cfg_data valid
//    cfg_ready  out  1            word accepted this cycle if cfg_valid
//    row_ram    out  DIMX*4       shared RAM bus to every row
//    row_wren   out  DIMY*SLOTS   write enables, row r slot s = bit r*SLOTS+s
//    busy       out  1            load in progress
//    done       out  1            one-cycle pulse after the last word
//  Revision    : 1.0  initial release
// ============================================================================
module cell_config_loader
    import cell_pkg::*;
#(
    parameter  int DIMX       = 64,
    parameter  int DIMY       = 64,
    parameter  int PORT_WIDTH = 32,
    localparam int SLOTS      = calc_slots(DIMX, PORT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [PORT_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [DIMX*4-1:0]       row_ram,
    output logic [DIMY*SLOTS-1:0]   row_wren,
    output logic                    busy,
    output logic                    done
);

    localparam int RAM_W  = DIMX * 4;
    localparam int NWREN  = DIMY * SLOTS;
    localparam int ROW_W  = idx_width(DIMY);
    localparam int SLOT_W = idx_width(SLOTS);
    localparam int FLAT_W = idx_width(NWREN);

    load_state_e        state_q,    state_d;
    logic [ROW_W-1:0]   row_idx_q,  row_idx_d;
    logic [SLOT_W-1:0]  slot_idx_q, slot_idx_d;
    logic [RAM_W-1:0]   row_ram_q,  row_ram_d;
    logic [NWREN-1:0]   row_wren_q, row_wren_d;

    logic               accept;
    logic               last_slot;
    logic               last_word;
    logic [FLAT_W-1:0]  flat_idx;

    assign cfg_ready = (state_q == ST_LOAD) && !abort;
    assign accept    = cfg_valid && cfg_ready;
    assign last_slot = (slot_idx_q == SLOT_W'(SLOTS - 1));
    assign last_word = last_slot && (row_idx_q == ROW_W'(DIMY - 1));
    assign flat_idx  = FLAT_W'(row_idx_q) * FLAT_W'(SLOTS) + FLAT_W'(slot_idx_q);

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        slot_idx_d = slot_idx_q;
        row_ram_d  = row_ram_q;
        row_wren_d = '0;        // enables live for exactly one accepted word

        unique case (state_q)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d    = ST_LOAD;
                    row_idx_d  = '0;
                    slot_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (slot_idx_q == SLOT_W'(s)) begin
                            row_ram_d[s*PORT_WIDTH +: PORT_WIDTH] = cfg_data;
                        end
                    end
                    row_wren_d = NWREN'(1) << flat_idx;

                    if (last_word) begin
                        state_d = ST_DONE;
                    end else if (last_slot) begin
                        slot_idx_d = '0;
                        row_idx_d  = row_idx_q + ROW_W'(1);
                    end else begin
                        slot_idx_d = slot_idx_q + SLOT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_idx_q  <= '0;
            slot_idx_q <= '0;
            row_ram_q  <= '0;
            row_wren_q <= '0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            slot_idx_q <= slot_idx_d;
            row_ram_q  <= row_ram_d;
            row_wren_q <= row_wren_d;
        end
    end

    assign row_ram  = row_ram_q;
    assign row_wren = row_wren_q;
    assign busy     = (state_q == ST_LOAD);
    assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cell_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_config_loader
//  Description : Randomized self-checking bench for cell_config_loader at
//                default parameters. A behavioural model tracks the load as a
//                flat word count k (row = k / SLOTS, slot = k % SLOTS) and an
//                image of the row RAM bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cell_config_loader;

    localparam int DIMX  = 64;
    localparam int DIMY  = 64;
    localparam int PW    = 32;
    localparam int SLOTS = DIMX * 4 / PW;
    localparam int NW    = DIMY * SLOTS;
    localparam int RAM_W = DIMX * 4;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [PW-1:0]     cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [RAM_W-1:0]  row_ram;
    logic [NW-1:0]     row_wren;
    logic              busy;
    logic              done;

    cell_config_loader #(
        .DIMX       (DIMX),
        .DIMY       (DIMY),
        .PORT_WIDTH (PW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .row_ram   (row_ram),
        .row_wren  (row_wren),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass   = 0;

    int               m_state;
    int               m_k;
    int               m_wren_k;
    logic [RAM_W-1:0] m_ram;
    int               wren_pulses;
    int               done_pulses;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_k      = 0;
        m_wren_k = -1;
        m_ram    = '0;
    endtask

    task automatic check_outputs();
        check("busy",     busy,                 (m_state == M_LOAD));
        check("done",     done,                 (m_state == M_DONE));
        check("wren_cnt", $countones(row_wren), (m_wren_k >= 0) ? 1 : 0);
        if (m_wren_k >= 0) begin
            check("wren_bit", row_wren[m_wren_k], 1'b1);
        end
        check("row_ram",  row_ram,              m_ram);
        if ($countones(row_wren) != 0) wren_pulses++;
        if (done) done_pulses++;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input logic s, input logic a, input logic v, input logic [PW-1:0] d);
        start     = s;
        abort     = a;
        cfg_valid = v;
        cfg_data  = d;
        #1;
        check("cfg_ready", cfg_ready, (m_state == M_LOAD) && !a);
        @(posedge clk);
        m_wren_k = -1;
        case (m_state)
            M_IDLE: begin
                if (s && !a) begin
                    m_state = M_LOAD;
                    m_k     = 0;
                end
            end
            M_LOAD: begin
                if (a) begin
                    m_state = M_IDLE;
                end else if (v) begin
                    m_ram[(m_k % SLOTS) * PW +: PW] = d;
                    m_wren_k = m_k;
                    m_k++;
                    if (m_k == NW) m_state = M_DONE;
                end
            end
            default: m_state = M_IDLE;
        endcase
        #1;
        check_outputs();
    endtask

    // Full load with valid asserted vpct% of the time; start is also pulsed
    // during LOAD (randomly) and always in DONE, where it must be ignored.
    task automatic run_load(input int vpct);
        wren_pulses = 0;
        done_pulses = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8 * NW && m_state != M_IDLE; i++) begin
            step((m_state == M_DONE) ? 1'b1 : ($urandom_range(0, 15) == 0),
                 1'b0,
                 ($urandom_range(0, 99) < vpct),
                 $urandom);
        end
        check("load_pulses", wren_pulses, NW);
        check("load_done",   done_pulses, 1);
        step(1'b0, 1'b0, 1'b1, $urandom);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cfg_ready, 1'b0);
        check_outputs();
        rst_n = 1'b1;

        // start and abort together in IDLE: stay idle
        step(1'b1, 1'b1, 1'b1, $urandom);
        step(1'b0, 1'b0, 1'b1, $urandom);

        // full load, 50% valid
        run_load(50);

        // abort after five accepted words, then restart from word 0
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, $urandom);
        check("pre_abort_k", m_k, 5);
        done_pulses = 0;
        step(1'b0, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $urandom);
        check("abort_no_done", done_pulses, 0);
        run_load(80);

        // asynchronous reset in the middle of a word
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, $urandom);
        cfg_valid = 1'b1;
        cfg_data  = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ready", cfg_ready, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, $urandom);

        // loading works after reset, mostly-valid stream
        run_load(95);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
